// File: rtl/bsg_dmc_pkg.sv
// Shared DMC application-interface types.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001
  } app_cmd_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables and a registered read port.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int unsigned els_p        = 256,
  parameter int unsigned data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        v_i,
  input  logic                        w_i,
  input  logic [$clog2(els_p)-1:0]    addr_i,
  input  logic [data_width_p-1:0]     data_i,
  input  logic [data_width_p/8-1:0]   write_mask_i,
  output logic [data_width_p-1:0]     data_o
);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int b = 0; b < data_width_p / 8; b++) begin
        if (write_mask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
    if (v_i && !w_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_dram_ctrl_app_responder.sv
// Responder side of the DMC app interface: stores write bursts in a byte-maskable
// SRAM and returns read bursts with valid/end framing.
module bsg_dram_ctrl_app_responder
  import bsg_dmc_pkg::*;
#(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 28,
  parameter int unsigned burst_len_p  = 2,
  parameter int unsigned els_p        = 256,
  parameter int unsigned lg_num_dma_p = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      app_en_i,
  output logic                      app_rdy_o,
  input  app_cmd_e                  app_cmd_i,
  input  logic [addr_width_p-1:0]   app_addr_i,
  input  logic [lg_num_dma_p-1:0]   app_addr_id_i,
  input  logic                      app_wdf_wren_i,
  output logic                      app_wdf_rdy_o,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_end_i,
  output logic                      app_rd_data_valid_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_end_o,
  output logic                      error_o
);

  localparam int unsigned lg_bytes = $clog2(data_width_p / 8);
  localparam int unsigned lg_els   = $clog2(els_p);
  localparam int unsigned lg_burst = $clog2(burst_len_p);
  localparam int unsigned cnt_w    = (lg_burst == 0) ? 1 : lg_burst;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e            state_q, state_d;
  logic [lg_els-1:0] idx_q, idx_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              rd_v_q, rd_end_q;
  logic              last_beat;
  logic              mem_v, mem_w;
  logic [lg_els-1:0] mem_addr;
  logic              unused_inputs;

  // Id and address bits outside the word index carry no meaning here.
  assign unused_inputs = ^{app_addr_i, app_addr_id_i};

  assign last_beat = (cnt_q == cnt_w'(burst_len_p - 1));
  assign mem_addr  = idx_q + lg_els'(cnt_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    error_d       = error_q;
    app_rdy_o     = 1'b0;
    app_wdf_rdy_o = 1'b0;
    mem_v         = 1'b0;
    mem_w         = 1'b0;
    unique case (state_q)
      StIdle: begin
        app_rdy_o = 1'b1;
        if (app_en_i) begin
          idx_d = app_addr_i[lg_bytes +: lg_els];
          cnt_d = '0;
          case (app_cmd_i)
            WR:      state_d = StWrite;
            RD:      state_d = StRead;
            default: error_d = 1'b1;
          endcase
        end
      end
      StWrite: begin
        app_wdf_rdy_o = 1'b1;
        if (app_wdf_wren_i) begin
          mem_v = 1'b1;
          mem_w = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (app_wdf_end_i != last_beat) error_d = 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      StRead: begin
        mem_v = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      rd_v_q   <= 1'b0;
      rd_end_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      // Framing flops line up with the SRAM's one-cycle read latency.
      rd_v_q   <= (state_q == StRead);
      rd_end_q <= (state_q == StRead) && last_beat;
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (els_p),
    .data_width_p (data_width_p)
  ) u_mem (
    .clk_i        (clk_i),
    .v_i          (mem_v),
    .w_i          (mem_w),
    .addr_i       (mem_addr),
    .data_i       (app_wdf_data_i),
    .write_mask_i (~app_wdf_mask_i),
    .data_o       (app_rd_data_o)
  );

  assign app_rd_data_valid_o = rd_v_q;
  assign app_rd_data_end_o   = rd_end_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_bsg_dram_ctrl_app_responder.sv
// Randomized bench for bsg_dram_ctrl_app_responder against a transaction-level model.
module tb_bsg_dram_ctrl_app_responder;
  import bsg_dmc_pkg::*;

  localparam int BL  = 2;
  localparam int ELS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        app_en;
  logic        app_rdy;
  app_cmd_e    app_cmd;
  logic [27:0] app_addr;
  logic [0:0]  app_addr_id;
  logic        wren;
  logic        wdf_rdy;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wend;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_end;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bsg_dram_ctrl_app_responder dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .app_en_i            (app_en),
    .app_rdy_o           (app_rdy),
    .app_cmd_i           (app_cmd),
    .app_addr_i          (app_addr),
    .app_addr_id_i       (app_addr_id),
    .app_wdf_wren_i      (wren),
    .app_wdf_rdy_o       (wdf_rdy),
    .app_wdf_data_i      (wdata),
    .app_wdf_mask_i      (wmask),
    .app_wdf_end_i       (wend),
    .app_rd_data_valid_o (rd_valid),
    .app_rd_data_o       (rd_data),
    .app_rd_data_end_o   (rd_end),
    .error_o             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: word memory, pending write burst, expected read beats.
  typedef struct {
    int          at;
    logic [31:0] d;
    logic        e;
  } beat_t;

  logic [31:0] mem [ELS];
  beat_t       rq[$];
  logic [31:0] got_q[$];
  logic        got_e[$];
  bit          wr_act = 0;
  logic [7:0]  wr_idx;
  int          wr_k;
  int          rd_free = 0;
  bit          exp_err = 0;

  always @(negedge clk) begin
    bit         exp_rdy;
    beat_t      b;
    logic [7:0] ix;
    if (rst) begin
      wr_act  = 0;
      rq.delete();
      rd_free = 0;
      exp_err = 0;
    end else begin
      exp_rdy = !wr_act && (cyc >= rd_free);
      check("app_rdy_o", app_rdy, exp_rdy);
      check("app_wdf_rdy_o", wdf_rdy, wr_act);
      check("error_o", err, exp_err);
      if (rq.size() != 0 && rq[0].at == cyc) begin
        b = rq.pop_front();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, b.d);
        check("rd_end", rd_end, b.e);
      end else begin
        check("rd_valid_idle", rd_valid, 0);
        check("rd_end_idle", rd_end, 0);
      end
      if (rd_valid) begin
        got_q.push_back(rd_data);
        got_e.push_back(rd_end);
      end
      if (wr_act && wren) begin
        ix = wr_idx + 8'(wr_k);
        for (int i = 0; i < 4; i++) if (!wmask[i]) mem[ix][8*i +: 8] = wdata[8*i +: 8];
        if (wend != (wr_k == BL - 1)) exp_err = 1;
        wr_k++;
        if (wr_k == BL) wr_act = 0;
      end else if (app_en && exp_rdy) begin
        if (app_cmd == WR) begin
          wr_act = 1;
          wr_idx = app_addr[9:2];
          wr_k   = 0;
        end else if (app_cmd == RD) begin
          for (int k = 0; k < BL; k++) begin
            ix = app_addr[9:2] + 8'(k);
            rq.push_back('{at: cyc + 2 + k, d: mem[ix], e: (k == BL - 1)});
          end
          rd_free = cyc + 1 + BL;
        end else begin
          exp_err = 1;
        end
      end
    end
  end

  function automatic logic [31:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic got_end_at(input int i);
    return (got_e.size() > i) ? got_e[i] : 1'bx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input app_cmd_e c, input logic [27:0] a);
    bit done = 0;
    app_en   = 1;
    app_cmd  = c;
    app_addr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = app_rdy;
      step(1);
    end
    app_en = 0;
    if (!done) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] m, input logic e, input int gap);
    bit done = 0;
    wren = 0;
    step(gap);
    wren  = 1;
    wdata = d;
    wmask = m;
    wend  = e;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = wdf_rdy;
      step(1);
    end
    wren = 0;
    wend = 0;
    if (!done) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic wr_burst(input logic [27:0] a, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] m0, input logic [3:0] m1, input logic e0,
                          input int gap);
    issue(WR, a);
    beat(d0, m0, e0, gap);
    beat(d1, m1, 1'b1, gap);
  endtask

  task automatic rd_wait(input logic [27:0] a);
    issue(RD, a);
    step(3);
  endtask

  initial begin
    rst = 1; app_en = 0; app_cmd = WR; app_addr = '0; app_addr_id = '0;
    wren = 0; wdata = '0; wmask = '0; wend = 0;
    #1;
    check("reset_rdy", app_rdy, 1);
    check("reset_wdf_rdy", wdf_rdy, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_error", err, 0);
    step(2);
    rst = 0;

    for (int w = 0; w < ELS / BL; w++) wr_burst(28'(w * 8), $urandom, $urandom, 0, 0, 0, 0);

    // Basic write then read
    wr_burst(28'h10, 32'hDEADBEEF, 32'h01234567, 0, 0, 0, 0);
    got_q.delete(); got_e.delete();
    rd_wait(28'h10);
    check("basic_b0", got_at(0), 32'hDEADBEEF);
    check("basic_b1", got_at(1), 32'h01234567);
    check("basic_e0", got_end_at(0), 0);
    check("basic_e1", got_end_at(1), 1);
    check("basic_err", err, 0);

    // Masked overwrite
    wr_burst(28'h10, 32'hAABBCCDD, 32'hFFFFFFFF, 4'b0011, 4'hF, 0, 0);
    got_q.delete(); got_e.delete();
    rd_wait(28'h10);
    check("mask_b0", got_at(0), 32'hAABBBEEF);
    check("mask_b1", got_at(1), 32'h01234567);

    // Wrap at the top of storage
    wr_burst(28'h3FC, 32'h11111111, 32'h22222222, 0, 0, 0, 0);
    got_q.delete(); got_e.delete();
    rd_wait(28'h0);
    check("wrap_rd0", got_at(0), 32'h22222222);
    got_q.delete(); got_e.delete();
    rd_wait(28'h3FC);
    check("wrap_rd3fc", got_at(0), 32'h11111111);

    // Command held during a gapped write burst
    issue(WR, 28'h20);
    app_en = 1; app_cmd = RD; app_addr = 28'h20;
    beat(32'h55555555, 0, 0, 3);
    beat(32'h66666666, 0, 1, 3);
    got_q.delete(); got_e.delete();
    rd_wait(28'h20);
    check("gap_b0", got_at(0), 32'h55555555);
    check("gap_b1", got_at(1), 32'h66666666);

    // Back-to-back reads
    got_q.delete(); got_e.delete();
    issue(RD, 28'h10);
    issue(RD, 28'h3FC);
    step(4);
    check("b2b_count", got_q.size(), 4);
    check("b2b_d0", got_at(0), 32'hAABBBEEF);
    check("b2b_d2", got_at(2), 32'h11111111);
    check("b2b_e0", got_end_at(0), 0);
    check("b2b_e1", got_end_at(1), 1);
    check("b2b_e2", got_end_at(2), 0);
    check("b2b_e3", got_end_at(3), 1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(1, 0) == 1)
        wr_burst(28'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom), 0,
                 $urandom_range(2, 0));
      else
        issue(RD, 28'($urandom));
      step($urandom_range(2, 0));
    end
    step(4);

    // End flag on the wrong beat makes error sticky
    wr_burst(28'h40, 32'hCAFEF00D, 32'h0BADC0DE, 0, 0, 1, 0);
    step(1);
    check("end_err_set", err, 1);
    rd_wait(28'h40);
    wr_burst(28'h48, $urandom, $urandom, 0, 0, 0, 1);
    rd_wait(28'h48);
    check("end_err_sticky", err, 1);

    // Asynchronous reset mid-write
    issue(WR, 28'h50);
    check("pre_rst_wdf_rdy", wdf_rdy, 1);
    rst = 1;
    #1;
    check("async_rdy", app_rdy, 1);
    check("async_wdf_rdy", wdf_rdy, 0);
    check("async_valid", rd_valid, 0);
    check("async_error", err, 0);
    step(1);
    rst = 0;

    // Unknown command flags error
    issue(app_cmd_e'(3'b010), 28'h0);
    check("illegal_cmd_err", err, 1);
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    check("illegal_cleared", err, 0);

    // Reset during read beat 0
    issue(RD, 28'h10);
    step(1);
    check("rst_rd_valid_pre", rd_valid, 1);
    rst = 1;
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_rdy", app_rdy, 1);
    check("rst_rd_end", rd_end, 0);
    step(1);
    rst = 0;

    // Function intact after reset
    wr_burst(28'h80, 32'h13579BDF, 32'h2468ACE0, 0, 0, 0, 0);
    got_q.delete(); got_e.delete();
    rd_wait(28'h80);
    check("post_rst_b0", got_at(0), 32'h13579BDF);
    check("post_rst_b1", got_at(1), 32'h2468ACE0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
